// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one read/write request at a time, services it
// after WAIT_CYCLES wait states and returns a one-cycle ack (optionally with err).
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_rd, lat_wr;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req, commit, src_rd, src_wr, src_err;
  logic [31:0]   src_addr, src_wdata;
  logic [AW-1:0] idx;

  assign req = mem_read | mem_write;

  // With zero wait states the commit edge is the accept edge, so the access
  // must be decoded from the live inputs rather than the latched copy.
  always_comb begin
    src_addr  = lat_addr;
    src_wdata = lat_wdata;
    src_rd    = lat_rd;
    src_wr    = lat_wr;
    if (state == IDLE) begin
      src_addr  = addr;
      src_wdata = wdata;
      src_rd    = mem_read;
      src_wr    = mem_write;
    end
  end

  assign src_err = (src_rd & src_wr) | (src_addr[1:0] != 2'b00) | (src_addr[31:AW+2] != '0);
  assign idx     = src_addr[AW+1:2];
  assign commit  = ((state == BUSY) && (cnt == 4'd0)) ||
                   ((state == IDLE) && req && (WAIT_CYCLES == 0));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (WAIT_CYCLES == 0) ? RESP : BUSY;
      BUSY:    if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      rdata     <= '0;
      err_q     <= 1'b0;
    end else begin
      if ((state == IDLE) && req) begin
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_rd    <= mem_read;
        lat_wr    <= mem_write;
        cnt       <= CNT_INIT;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q <= src_err;
        rdata <= (src_err || src_wr) ? '0 : mem[idx];
      end
    end
  end

  // Storage is not reset; a reset edge suppresses any commit in flight.
  always_ff @(posedge clk) begin
    if (!rst && commit && !src_err && src_wr) mem[idx] <= src_wdata;
  end

  assign ack   = (state == RESP);
  assign err   = (state == RESP) & err_q;
  assign stall = !rst & (((state == IDLE) & req) | (state == BUSY));

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: DUT a uses two wait states, DUT b zero wait states; a
// monitor pops expected responses whenever either DUT acks.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_rd, a_wr, a_ack, a_err, a_stall;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_rd, b_wr, b_ack, b_err, b_stall;
  logic [31:0] b_addr, b_wdata, b_rdata;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr), .addr(a_addr),
    .wdata(a_wdata), .rdata(a_rdata), .ack(a_ack), .err(a_err), .stall(a_stall)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .ack(b_ack), .err(b_err), .stall(b_stall)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      b_rd = rd; b_wr = wr; b_addr = a; b_wdata = d;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = a; a_wdata = d;
    end
  endtask

  // Issue one request, push its expected response, and follow stall until ack.
  task automatic txn(input bit sel, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err,
                     input bit predriven, input bit churn, input bit keep);
    bit got;
    int w;
    w = sel ? 0 : 2;
    if (!predriven) begin
      @(posedge clk); #1;
      drive(sel, rd, wr, a, d);
    end
    @(negedge clk);
    chk("stall_on_request", 32'(sel ? b_stall : a_stall), 32'd1);
    @(posedge clk); #1;
    if (sel) qb.push_back('{exp_rd, exp_err, cyc + w});
    else     qa.push_back('{exp_rd, exp_err, cyc + w});
    if (churn) drive(sel, rd, wr, a ^ 32'h40, ~d);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sel ? b_ack : a_ack) begin
        chk("stall_on_ack", 32'(sel ? b_stall : a_stall), 32'd0);
        got = 1'b1;
      end else begin
        chk("stall_while_busy", 32'(sel ? b_stall : a_stall), 32'd1);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got no ack expected ack within 40 cycles (dut %0d)", sel);
    end
    if (!keep) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (a_ack) begin
          if (qa.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_ack: got ack expected none (cycle %0d)", cyc);
          end else begin
            ea = qa.pop_front();
            chk("a_rdata", a_rdata, ea.rdata);
            chk("a_err", 32'(a_err), 32'(ea.err));
            chk("a_latency", 32'(cyc), 32'(ea.cyc));
          end
        end else begin
          chk("a_err_without_ack", 32'(a_err), 32'd0);
        end
        if (b_ack) begin
          if (qb.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected_ack: got ack expected none (cycle %0d)", cyc);
          end else begin
            eb = qb.pop_front();
            chk("b_rdata", b_rdata, eb.rdata);
            chk("b_err", 32'(b_err), 32'(eb.err));
            chk("b_latency", 32'(cyc), 32'(eb.cyc));
          end
        end else begin
          chk("b_err_without_ack", 32'(b_err), 32'd0);
        end
      end
    join_none

    // Power-up reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_a_stall", 32'(a_stall), 32'd0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_b_stall", 32'(b_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T2: write then read with two wait states
    txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0);
    txn(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);

    // T3: zero wait states, back-to-back reads with the request held high
    txn(1, 0, 1, 32'h0, 32'hA5A5A5A5, 32'h0, 0, 0, 0, 0);
    txn(1, 0, 1, 32'h4, 32'h5A5A5A5A, 32'h0, 0, 0, 0, 0);
    txn(1, 1, 0, 32'h0, 32'h0, 32'hA5A5A5A5, 0, 0, 0, 1);
    txn(1, 1, 0, 32'h4, 32'h0, 32'h5A5A5A5A, 0, 0, 0, 0);

    // T4: error cases and the top-of-range word
    txn(0, 1, 0, 32'h6, 32'h0, 32'h0, 1, 0, 0, 0);
    txn(0, 1, 0, 32'h400, 32'h0, 32'h0, 1, 0, 0, 0);
    txn(0, 1, 1, 32'h10, 32'h12345678, 32'h0, 1, 0, 0, 0);
    txn(0, 0, 1, 32'h12, 32'h12345678, 32'h0, 1, 0, 0, 0);
    txn(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
    txn(0, 0, 1, 32'h3FC, 32'h0BADF00D, 32'h0, 0, 0, 0, 0);
    txn(0, 1, 0, 32'h3FC, 32'h0, 32'h0BADF00D, 0, 0, 0, 0);
    @(negedge clk);
    chk("rdata_hold_after_ack", a_rdata, 32'h0BADF00D);

    // T6: address/data churn after accept
    txn(0, 0, 1, 32'h30, 32'hCAFEF00D, 32'h0, 0, 0, 1, 0);
    txn(0, 1, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0);
    txn(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1, 0);

    // T5: reset in the first BUSY cycle drops the write
    txn(0, 0, 1, 32'h20, 32'h11111111, 32'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h20, 32'h00000055);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(a_ack), 32'd0);
      chk("abort_no_stall", 32'(a_stall), 32'd0);
    end
    txn(0, 1, 0, 32'h20, 32'h0, 32'h11111111, 0, 0, 0, 0);

    // T1: reset held with a read pending, accepted right after release
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t1_stall", 32'(a_stall), 32'd0);
      chk("t1_ack", 32'(a_ack), 32'd0);
      chk("t1_err", 32'(a_err), 32'd0);
      chk("t1_rdata", a_rdata, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    txn(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
